// File: rtl/whack_pkg.sv
// Shared types and sizing helpers for the whack-a-mole session controller and game core.
package whack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_COUNTIN = 3'd2,
    ST_PLAY    = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  localparam int SCORE_W_DEF  = 8;
  localparam int TICK_DIV_DEF = 1000;
  localparam int DIV_W_DEF    = $clog2(TICK_DIV_DEF);

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/whack_tick_div.sv
// Clearable modulo-TICK_DIV counter; tick is a one-cycle pulse on the last count.
// Latency: first tick TICK_DIV cycles after clr drops with en high. No backpressure.
module whack_tick_div
  import whack_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_w(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/whack_session_ctrl.sv
// Game session sequencer: start, arm, 3-2-1 count-in, pause, game-over, high score (WHACK_HISCORE_EN).
// Latency: play_en rises 1 + ARM_CYCLES + COUNTIN_TICKS*TICK_DIV cycles after a start press.
// Backpressure: none; button edges outside their accepting states are dropped.
module whack_session_ctrl
  import whack_pkg::*;
#(
  parameter int TICK_DIV      = 1000,
  parameter int COUNTIN_TICKS = 3,
  parameter int ARM_CYCLES    = 2,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               game_end,
  input  logic [SCORE_W-1:0] score,
  output logic               core_rst_n,
  output logic               play_en,
  output logic [1:0]         countin_digit,
  output logic [2:0]         state_o,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  localparam int ARM_W = cnt_w(ARM_CYCLES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  state_e           state;
  logic [ARM_W-1:0] arm_cnt;
  logic             start_q;
  logic             pause_q;
  logic             tick;

  // Edge registers reset high so a button held through reset never fires.
  wire start_rise = start_btn & ~start_q;
  wire pause_rise = pause_btn & ~pause_q;

  whack_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_COUNTIN),
    .en  (state == ST_COUNTIN),
    .tick(tick)
  );

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      core_rst_n    <= 1'b0;
      play_en       <= 1'b0;
      countin_digit <= 2'd0;
      arm_cnt       <= '0;
      start_q       <= 1'b1;
      pause_q       <= 1'b1;
    end else begin
      start_q <= start_btn;
      pause_q <= pause_btn;
      case (state)
        ST_IDLE: begin
          if (start_rise) state <= ST_ARM;
        end
        ST_ARM: begin
          if (arm_cnt == ARM_LAST) begin
            state         <= ST_COUNTIN;
            core_rst_n    <= 1'b1;
            countin_digit <= 2'(COUNTIN_TICKS);
            arm_cnt       <= '0;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        ST_COUNTIN: begin
          if (tick) begin
            if (countin_digit > 2'd1) begin
              countin_digit <= countin_digit - 2'd1;
            end else begin
              state         <= ST_PLAY;
              countin_digit <= 2'd0;
              play_en       <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (game_end) begin
            state   <= ST_OVER;
            play_en <= 1'b0;
          end else if (pause_rise) begin
            state   <= ST_PAUSE;
            play_en <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_rise) begin
            state      <= ST_ARM;
            core_rst_n <= 1'b0;
            arm_cnt    <= '0;
          end else if (pause_rise) begin
            state   <= ST_PLAY;
            play_en <= 1'b1;
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            state      <= ST_ARM;
            core_rst_n <= 1'b0;
            arm_cnt    <= '0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          core_rst_n    <= 1'b0;
          play_en       <= 1'b0;
          countin_digit <= 2'd0;
          arm_cnt       <= '0;
        end
      endcase
    end
  end

`ifdef WHACK_HISCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic               new_q;

  // Captured on the PLAY->OVER edge so new_high lands on the first OVER cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_q <= '0;
      new_q  <= 1'b0;
    end else begin
      new_q <= 1'b0;
      if (state == ST_PLAY && game_end && score > high_q) begin
        high_q <= score;
        new_q  <= 1'b1;
      end
    end
  end

  assign high_score = high_q;
  assign new_high   = new_q;
`else
  logic unused_score;
  assign unused_score = ^score;
  assign high_score   = '0;
  assign new_high     = 1'b0;
`endif

endmodule

// File: tb/tb_whack_session_ctrl.sv
// Directed bench for whack_session_ctrl with TICK_DIV=4, COUNTIN_TICKS=3, ARM_CYCLES=2.
module tb_whack_session_ctrl;

  localparam int SW = 8;
`ifdef WHACK_HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_btn;
  logic          pause_btn;
  logic          game_end;
  logic [SW-1:0] score;
  logic          core_rst_n;
  logic          play_en;
  logic [1:0]    countin_digit;
  logic [2:0]    state_o;
  logic [SW-1:0] high_score;
  logic          new_high;

  int checks   = 0;
  int failures = 0;
  int nh_cnt   = 0;

  always #5 clk = ~clk;

  whack_session_ctrl #(
    .TICK_DIV     (4),
    .COUNTIN_TICKS(3),
    .ARM_CYCLES   (2),
    .SCORE_W      (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .game_end     (game_end),
    .score        (score),
    .core_rst_n   (core_rst_n),
    .play_en      (play_en),
    .countin_digit(countin_digit),
    .state_o      (state_o),
    .high_score   (high_score),
    .new_high     (new_high)
  );

  always @(negedge clk) if (new_high === 1'b1) nh_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_st, exp_dg;
    rst = 1'b1; start_btn = 1'b1; pause_btn = 1'b0; game_end = 1'b0; score = '0;
    step(2);
    check("rst_state", state_o, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_play_en", play_en, 0);
    check("rst_digit", countin_digit, 0);
    check("rst_high", high_score, 0);
    check("rst_new_high", new_high, 0);

    // Start held through reset release must not fire.
    rst = 1'b0;
    step(3);
    check("held_start_idle", state_o, 0);
    start_btn = 1'b0;
    step(1);
    start_btn = 1'b1;

    // Edge count t from the button press: ARM t1-2, digits 3/2/1 for 4 each, PLAY at t15.
    for (int t = 1; t <= 15; t++) begin
      step(1);
      exp_st = (t <= 2) ? 1 : (t <= 14) ? 2 : 3;
      exp_dg = (t < 3) ? 0 : (t <= 6) ? 3 : (t <= 10) ? 2 : (t <= 14) ? 1 : 0;
      check($sformatf("seq_state_t%0d", t), state_o, exp_st);
      check($sformatf("seq_digit_t%0d", t), countin_digit, exp_dg);
      check($sformatf("seq_play_en_t%0d", t), play_en, (t == 15) ? 1 : 0);
      check($sformatf("seq_core_rst_n_t%0d", t), core_rst_n, (t >= 3) ? 1 : 0);
      if (t == 2)  start_btn = 1'b0;
      if (t == 5)  pause_btn = 1'b1;
      if (t == 8)  pause_btn = 1'b0;
      if (t == 9)  start_btn = 1'b1;
      if (t == 12) start_btn = 1'b0;
    end

    // Pause toggling and ignored start in PLAY.
    score = 8'd3;
    start_btn = 1'b1;
    step(1);
    check("play_ignores_start", state_o, 3);
    start_btn = 1'b0;
    pause_btn = 1'b1;
    step(1);
    check("pause_state", state_o, 4);
    check("pause_play_en", play_en, 0);
    check("pause_core_rst_n", core_rst_n, 1);
    pause_btn = 1'b0;
    step(1);
    pause_btn = 1'b1;
    step(1);
    check("resume_state", state_o, 3);
    check("resume_play_en", play_en, 1);
    pause_btn = 1'b0;
    step(1);
    pause_btn = 1'b1;
    step(1);
    check("pause2_state", state_o, 4);
    pause_btn = 1'b0;
    step(1);

    // Start and pause together in PAUSE: start wins, restart holds core reset 2 cycles.
    start_btn = 1'b1; pause_btn = 1'b1;
    step(1);
    check("restart_state", state_o, 1);
    check("restart_core_rst_n_1", core_rst_n, 0);
    check("restart_play_en", play_en, 0);
    start_btn = 1'b0; pause_btn = 1'b0;
    step(1);
    check("restart_core_rst_n_2", core_rst_n, 0);
    step(1);
    check("restart_countin", state_o, 2);
    check("restart_core_rst_n_3", core_rst_n, 1);
    check("restart_digit", countin_digit, 3);
    step(12);
    check("restart_play", state_o, 3);
    check("restart_play_en_on", play_en, 1);

    // game_end with pause_rise in the same cycle: OVER wins.
    score = 8'd7; game_end = 1'b1; pause_btn = 1'b1;
    step(1);
    check("over_state", state_o, 5);
    check("over_play_en", play_en, 0);
    check("over_new_high", new_high, HS ? 1 : 0);
    check("over_high", high_score, HS ? 7 : 0);
    step(1);
    check("over_hold", state_o, 5);
    check("over_new_high_clear", new_high, 0);
    game_end = 1'b0; pause_btn = 1'b0;

    // Second game ends lower: high score kept, no new pulse.
    start_btn = 1'b1;
    step(1);
    check("game2_arm", state_o, 1);
    start_btn = 1'b0;
    step(14);
    check("game2_play", state_o, 3);
    score = 8'd5; game_end = 1'b1;
    step(1);
    check("game2_over", state_o, 5);
    check("game2_new_high", new_high, 0);
    check("game2_high", high_score, HS ? 7 : 0);
    game_end = 1'b0;
    step(1);

    // Asynchronous reset during count-in digit 2.
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(6);
    check("pre_rst_digit", countin_digit, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_state", state_o, 0);
    check("arst_core_rst_n", core_rst_n, 0);
    check("arst_play_en", play_en, 0);
    check("arst_digit", countin_digit, 0);
    check("arst_high", high_score, 0);
    check("arst_new_high", new_high, 0);
    step(2);
    rst = 1'b0;
    step(2);
    check("post_rst_idle", state_o, 0);

    check("new_high_pulses", nh_cnt, HS ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
